// File: rtl/clk_div_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_pkg
// Shared definitions for the programmable clock divider.
//   RATIO_W_DEF : default width of the ratio input and internal counter
//   BYPASS_MAX  : largest ratio that selects bypass (the reference passes through)
//   ratio_t     : ratio type at the default width
//   half_hi(n)  : ceil(n/2), the number of ref cycles pos_q stays high per period
// -----------------------------------------------------------------------------
package clk_div_pkg;

  localparam int unsigned RATIO_W_DEF = 8;
  localparam int unsigned BYPASS_MAX  = 1;

  typedef logic [RATIO_W_DEF-1:0] ratio_t;

  // Evaluated in 32 bits so N = 2^RATIO_W-1 cannot overflow the +1.
  function automatic logic [31:0] half_hi(input logic [31:0] n);
    return (n + 32'd1) >> 1;
  endfunction

endpackage

// File: rtl/clk_div_ratio_shadow.sv
// -----------------------------------------------------------------------------
// clk_div_ratio_shadow
// Holds a requested ratio and moves it into the active ratio only at an
// output-period boundary supplied by the divider core.
//
// Load/ack handshake: load is a one-cycle strobe with no back-pressure; the
// shadow always accepts it and a later load overwrites an earlier one that
// has not yet been applied. ack pulses high for exactly one cycle, starting
// on the edge where the shadow value becomes active.
//
// Ports:
//   clk, rst_n    : reference clock, asynchronous active-low reset
//   load          : strobe, captures ratio_in into the shadow
//   ratio_in      : requested ratio
//   boundary      : high when the core may switch ratio on this edge
//   active_ratio  : ratio currently in use
//   next_ratio    : ratio in use after this edge
//   apply         : the shadow is copied to the active ratio on this edge
//   pending       : a shadow value is waiting to be applied
//   shadow_ratio  : the waiting value
//   ack           : registered one-cycle acknowledge
// -----------------------------------------------------------------------------
module clk_div_ratio_shadow
  import clk_div_pkg::*;
#(
  parameter int unsigned RATIO_W       = RATIO_W_DEF,
  parameter int unsigned DEFAULT_RATIO = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [RATIO_W-1:0] ratio_in,
  input  logic               boundary,
  output logic [RATIO_W-1:0] active_ratio,
  output logic [RATIO_W-1:0] next_ratio,
  output logic               apply,
  output logic               pending,
  output logic [RATIO_W-1:0] shadow_ratio,
  output logic               ack
);

  localparam logic [RATIO_W-1:0] RATIO_RST = RATIO_W'(DEFAULT_RATIO);

  logic [RATIO_W-1:0] shadow_q, shadow_d;
  logic [RATIO_W-1:0] active_q, active_d;
  logic               pending_q, pending_d;
  logic               ack_q, ack_d;

  always_comb begin
    // The copy decision uses the pending flag from before this edge, so a
    // load landing on a boundary edge waits for the following boundary.
    apply     = pending_q & boundary;
    shadow_d  = load ? ratio_in : shadow_q;
    pending_d = load | (pending_q & ~apply);
    active_d  = apply ? shadow_q : active_q;
    ack_d     = apply;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q  <= RATIO_RST;
      active_q  <= RATIO_RST;
      pending_q <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      ack_q     <= ack_d;
    end
  end

  assign active_ratio = active_q;
  assign next_ratio   = active_d;
  assign pending      = pending_q;
  assign shadow_ratio = shadow_q;
  assign ack          = ack_q;

endmodule

// File: rtl/clock_divider_prog.sv
// -----------------------------------------------------------------------------
// clock_divider_prog
// Runtime-programmable integer clock divider with 50% duty for even and odd
// ratios. Ratios 0 and 1 pass the reference clock through (gated by enable).
// New ratios are taken at output-period boundaries only.
//
// Ports:
//   I_ref_clk    : reference clock
//   I_rst_n      : asynchronous active-low reset
//   I_clk_en     : divider enable; low forces the output low
//   I_div_ratio  : requested ratio N
//   I_ratio_load : one-cycle strobe capturing I_div_ratio
//   O_div_clk    : divided or bypassed clock
//   O_ratio_ack  : one-cycle pulse when a loaded ratio becomes active
//   O_tick       : one-cycle pulse on the first ref cycle of each output period
// -----------------------------------------------------------------------------
module clock_divider_prog
  import clk_div_pkg::*;
#(
  parameter int unsigned RATIO_W       = RATIO_W_DEF,
  parameter int unsigned DEFAULT_RATIO = 4
) (
  input  logic               I_ref_clk,
  input  logic               I_rst_n,
  input  logic               I_clk_en,
  input  logic [RATIO_W-1:0] I_div_ratio,
  input  logic               I_ratio_load,
  output logic               O_div_clk,
  output logic               O_ratio_ack,
  output logic               O_tick
);

  localparam logic [RATIO_W-1:0] BYP_LIMIT   = RATIO_W'(BYPASS_MAX);
  localparam logic               BYP_SEL_RST = (DEFAULT_RATIO <= BYPASS_MAX);

  logic [RATIO_W-1:0] cnt_q, cnt_d;
  logic               en_q, en_d;
  logic               pos_q, pos_d;
  logic               neg_q, neg_d;
  logic               byp_sel_q, byp_sel_d;

  logic [RATIO_W-1:0] active_ratio;
  logic [RATIO_W-1:0] next_ratio;
  logic [RATIO_W-1:0] shadow_ratio;
  logic               apply;
  logic               pending;
  logic               ratio_ack;

  logic               bypass_now;
  logic               bypass_next;
  logic               pend_to_div;
  logic               wrap;
  logic               boundary;
  logic               div_out;

  clk_div_ratio_shadow #(
    .RATIO_W       (RATIO_W),
    .DEFAULT_RATIO (DEFAULT_RATIO)
  ) u_shadow (
    .clk          (I_ref_clk),
    .rst_n        (I_rst_n),
    .load         (I_ratio_load),
    .ratio_in     (I_div_ratio),
    .boundary     (boundary),
    .active_ratio (active_ratio),
    .next_ratio   (next_ratio),
    .apply        (apply),
    .pending      (pending),
    .shadow_ratio (shadow_ratio),
    .ack          (ratio_ack)
  );

  always_comb begin
    bypass_now  = (active_ratio <= BYP_LIMIT);
    bypass_next = (next_ratio <= BYP_LIMIT);
    pend_to_div = pending & (shadow_ratio > BYP_LIMIT);
    wrap        = en_q & ~bypass_now & (cnt_q == active_ratio - RATIO_W'(1));
    // While disabled or bypassing there is no period in flight, so any edge
    // is a boundary.
    boundary    = ~en_q | bypass_now | wrap;
  end

  always_comb begin
    en_d  = I_clk_en;
    cnt_d = '0;
    pos_d = 1'b0;
    if (I_clk_en && !bypass_next) begin
      // Start-up, ratio change and wrap all begin a fresh period at count 0.
      if (en_q && !apply && !wrap) begin
        cnt_d = cnt_q + RATIO_W'(1);
      end
      pos_d = (32'(cnt_d) < half_hi(32'(next_ratio)));
    end
  end

  always_comb begin
    neg_d = pos_q;
    // The bypass path is switched on the falling ref edge so the select never
    // moves while the reference is high. It is dropped as soon as a divide
    // ratio is waiting, letting the final bypass pulse finish cleanly before
    // the divider takes over.
    byp_sel_d = bypass_now & ~pend_to_div;
  end

  always_ff @(posedge I_ref_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      cnt_q <= '0;
      en_q  <= 1'b0;
      pos_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      en_q  <= en_d;
      pos_q <= pos_d;
    end
  end

  // Falling-edge flops: neg_q supplies the extra half cycle for odd ratios.
  always_ff @(negedge I_ref_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      neg_q     <= 1'b0;
      byp_sel_q <= BYP_SEL_RST;
    end else begin
      neg_q     <= neg_d;
      byp_sel_q <= byp_sel_d;
    end
  end

  always_comb begin
    // Odd ratios: pos_q AND its half-cycle-late copy trims the high phase
    // to N/2 ref cycles; pos_q is forced low in bypass so the OR is safe.
    div_out     = active_ratio[0] ? (pos_q & neg_q) : pos_q;
    O_div_clk   = (byp_sel_q & I_ref_clk & en_q) | div_out;
    O_tick      = en_q & (bypass_now | (cnt_q == '0));
    O_ratio_ack = ratio_ack;
  end

endmodule
